// File: rtl/inst_fetch_if.sv
// Fetch-unit bus: instruction-memory port plus the decode handshake and the
// redirect request from execute. The fetch unit is the master.
interface inst_fetch_if;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_fault;

  modport master (
    output imem_pc, if_valid, if_instr, if_pc, if_fault,
    input  imem_instr, redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_pc, if_valid, if_instr, if_pc, if_fault,
    output imem_instr, redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the fetch PC, reads a combinational
// instruction memory, buffers words in a small circular queue and hands them
// to decode over valid/ready. Redirects flush the queue; bad PCs produce a
// single fault entry and stop fetching until the next redirect.
module inst_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned MEM_SIZE_BYTES = 1024,
  parameter int unsigned QUEUE_DEPTH    = 2
) (
  input  logic         clk,
  input  logic         reset,
  inst_fetch_if.master bus
);

  localparam int unsigned          PTR_W    = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned          CNT_W    = $clog2(QUEUE_DEPTH + 1);
  localparam logic [31:0]          LAST_PC  = 32'(MEM_SIZE_BYTES - 4);
  localparam logic [CNT_W-1:0]     DEPTH_C  = CNT_W'(QUEUE_DEPTH);
  localparam logic [PTR_W-1:0]     LAST_PTR = PTR_W'(QUEUE_DEPTH - 1);
  localparam logic [31:0]          NOP_INSTR = 32'h0000_0013;

  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_HALT  = 1'b1;

  logic [0:0]       r_state;
  logic [31:0]      r_fetch_pc;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;

  logic [31:0]      r_q_pc    [QUEUE_DEPTH];
  logic [31:0]      r_q_instr [QUEUE_DEPTH];
  logic             r_q_fault [QUEUE_DEPTH];

  logic             w_fault;
  logic             w_pop;
  logic             w_push;
  logic [31:0]      w_entry_instr;

  // Circular-buffer pointer increment with wrap at QUEUE_DEPTH.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Misaligned or beyond the last word of memory (unsigned compare).
  assign w_fault = (r_fetch_pc[1:0] != 2'b00) || (r_fetch_pc > LAST_PC);

  assign bus.if_valid = (r_count != '0);
  assign w_pop        = bus.if_valid && bus.if_ready;

  // A full queue can still take a push when the head leaves this cycle.
  // Redirect voids everything, so it masks the push here.
  assign w_push = (r_state == ST_FETCH) && !bus.redirect_valid &&
                  ((r_count < DEPTH_C) || w_pop);

  assign w_entry_instr = w_fault ? NOP_INSTR : bus.imem_instr;

  assign bus.imem_pc  = r_fetch_pc;
  assign bus.if_pc    = r_q_pc[r_rd_ptr];
  assign bus.if_instr = r_q_instr[r_rd_ptr];
  assign bus.if_fault = r_q_fault[r_rd_ptr];

  // Fetch PC, FSM, queue pointers and occupancy.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_FETCH;
      r_fetch_pc <= RESET_PC;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else if (bus.redirect_valid) begin
      r_state    <= ST_FETCH;
      r_fetch_pc <= bus.redirect_pc;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
        if (w_fault) begin
          r_state <= ST_HALT;
        end else begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage: write the fetched (or fault) entry at the tail.
  // NOTE: the entries are reset because the head drives if_* directly and
  // those outputs must read zero out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
        r_q_pc[i]    <= '0;
        r_q_instr[i] <= '0;
        r_q_fault[i] <= 1'b0;
      end
    end else if (w_push) begin
      r_q_pc[r_wr_ptr]    <= r_fetch_pc;
      r_q_instr[r_wr_ptr] <= w_entry_instr;
      r_q_fault[r_wr_ptr] <= w_fault;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: reset, streaming, back-pressure, redirect,
// misaligned fault, end-of-memory fault and asynchronous reset.
module tb_inst_fetch;

  logic clk;
  logic reset;
  logic mem_zero;
  int   n_tests;
  int   n_fail;

  inst_fetch_if bus ();

  inst_fetch #(
    .RESET_PC       (32'h0000_0000),
    .MEM_SIZE_BYTES (1024),
    .QUEUE_DEPTH    (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return {~pc[15:0], pc[15:0]};
  endfunction

  // Combinational instruction memory.
  assign bus.imem_instr = mem_zero ? 32'h0000_0013 : mem_word(bus.imem_pc);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    step();
    bus.redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    n_tests++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.if_valid); end
    n_tests++; if (bus.imem_pc !== 32'h0) begin n_fail++; $display("FAIL reset_imem_pc: got %h want 00000000", bus.imem_pc); end
    n_tests++; if (bus.if_pc !== 32'h0) begin n_fail++; $display("FAIL reset_if_pc: got %h want 00000000", bus.if_pc); end
    n_tests++; if (bus.if_instr !== 32'h0) begin n_fail++; $display("FAIL reset_if_instr: got %h want 00000000", bus.if_instr); end
    n_tests++; if (bus.if_fault !== 1'b0) begin n_fail++; $display("FAIL reset_if_fault: got %b want 0", bus.if_fault); end
  endtask

  task automatic test_stream();
    mem_zero    = 1'b1;
    bus.if_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      n_tests++; if (bus.if_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 1", i, bus.if_valid); end
      n_tests++; if (bus.if_pc !== 32'(4 * i)) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h want %h", i, bus.if_pc, 32'(4 * i)); end
      n_tests++; if (bus.if_fault !== 1'b0) begin n_fail++; $display("FAIL stream_fault[%0d]: got %b want 0", i, bus.if_fault); end
      n_tests++; if (bus.if_instr !== 32'h13) begin n_fail++; $display("FAIL stream_instr[%0d]: got %h want 00000013", i, bus.if_instr); end
    end
  endtask

  task automatic test_backpressure();
    mem_zero     = 1'b0;
    bus.if_ready = 1'b0;
    reset        = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (5) step();
    n_tests++; if (bus.imem_pc !== 32'h8) begin n_fail++; $display("FAIL bp_imem_pc_hold: got %h want 00000008", bus.imem_pc); end
    n_tests++; if (dut.r_count !== 2'd2) begin n_fail++; $display("FAIL bp_count: got %0d want 2", dut.r_count); end
    n_tests++; if (bus.if_pc !== 32'h0) begin n_fail++; $display("FAIL bp_head_pc: got %h want 00000000", bus.if_pc); end
    bus.if_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (bus.if_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", i, bus.if_valid); end
      n_tests++; if (bus.if_pc !== 32'(4 * i)) begin n_fail++; $display("FAIL bp_pc[%0d]: got %h want %h", i, bus.if_pc, 32'(4 * i)); end
      n_tests++; if (bus.if_instr !== mem_word(32'(4 * i))) begin n_fail++; $display("FAIL bp_instr[%0d]: got %h want %h", i, bus.if_instr, mem_word(32'(4 * i))); end
      step();
    end
    n_tests++; if (bus.if_pc !== 32'h10) begin n_fail++; $display("FAIL bp_next_pc: got %h want 00000010", bus.if_pc); end
  endtask

  task automatic test_redirect();
    bus.if_ready = 1'b1;
    do_redirect(32'h40);
    n_tests++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL rd_valid_n1: got %b want 0", bus.if_valid); end
    n_tests++; if (bus.imem_pc !== 32'h40) begin n_fail++; $display("FAIL rd_imem_pc_n1: got %h want 00000040", bus.imem_pc); end
    n_tests++; if (dut.r_count !== 2'd0) begin n_fail++; $display("FAIL rd_count_n1: got %0d want 0", dut.r_count); end
    step();
    n_tests++; if (bus.if_valid !== 1'b1) begin n_fail++; $display("FAIL rd_valid_n2: got %b want 1", bus.if_valid); end
    n_tests++; if (bus.if_pc !== 32'h40) begin n_fail++; $display("FAIL rd_pc_n2: got %h want 00000040", bus.if_pc); end
    n_tests++; if (bus.if_instr !== 32'hFFBF_0040) begin n_fail++; $display("FAIL rd_instr_n2: got %h want ffbf0040", bus.if_instr); end
    step();
    n_tests++; if (bus.if_pc !== 32'h44) begin n_fail++; $display("FAIL rd_pc_n3: got %h want 00000044", bus.if_pc); end
  endtask

  task automatic test_fault();
    bus.if_ready = 1'b1;
    do_redirect(32'h42);
    n_tests++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL flt_valid_n1: got %b want 0", bus.if_valid); end
    step();
    n_tests++; if (bus.if_valid !== 1'b1) begin n_fail++; $display("FAIL flt_valid: got %b want 1", bus.if_valid); end
    n_tests++; if (bus.if_fault !== 1'b1) begin n_fail++; $display("FAIL flt_fault: got %b want 1", bus.if_fault); end
    n_tests++; if (bus.if_pc !== 32'h42) begin n_fail++; $display("FAIL flt_pc: got %h want 00000042", bus.if_pc); end
    n_tests++; if (bus.if_instr !== 32'h13) begin n_fail++; $display("FAIL flt_instr: got %h want 00000013", bus.if_instr); end
    n_tests++; if (bus.imem_pc !== 32'h42) begin n_fail++; $display("FAIL flt_imem_pc: got %h want 00000042", bus.imem_pc); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL flt_halt_valid[%0d]: got %b want 0", i, bus.if_valid); end
      n_tests++; if (bus.imem_pc !== 32'h42) begin n_fail++; $display("FAIL flt_halt_pc[%0d]: got %h want 00000042", i, bus.imem_pc); end
    end
    do_redirect(32'h0);
    step();
    n_tests++; if (bus.if_valid !== 1'b1) begin n_fail++; $display("FAIL flt_resume_valid: got %b want 1", bus.if_valid); end
    n_tests++; if (bus.if_pc !== 32'h0) begin n_fail++; $display("FAIL flt_resume_pc: got %h want 00000000", bus.if_pc); end
    n_tests++; if (bus.if_fault !== 1'b0) begin n_fail++; $display("FAIL flt_resume_fault: got %b want 0", bus.if_fault); end
  endtask

  task automatic test_end_of_memory();
    bus.if_ready = 1'b1;
    do_redirect(32'h3F8);
    step();
    n_tests++; if (bus.if_pc !== 32'h3F8 || bus.if_fault !== 1'b0) begin n_fail++; $display("FAIL eom_3f8: got pc %h fault %b want 000003f8 0", bus.if_pc, bus.if_fault); end
    step();
    n_tests++; if (bus.if_pc !== 32'h3FC || bus.if_fault !== 1'b0) begin n_fail++; $display("FAIL eom_3fc: got pc %h fault %b want 000003fc 0", bus.if_pc, bus.if_fault); end
    n_tests++; if (bus.if_instr !== 32'hFC03_03FC) begin n_fail++; $display("FAIL eom_3fc_instr: got %h want fc0303fc", bus.if_instr); end
    step();
    n_tests++; if (bus.if_pc !== 32'h400 || bus.if_fault !== 1'b1) begin n_fail++; $display("FAIL eom_400: got pc %h fault %b want 00000400 1", bus.if_pc, bus.if_fault); end
    n_tests++; if (bus.if_instr !== 32'h13) begin n_fail++; $display("FAIL eom_400_instr: got %h want 00000013", bus.if_instr); end
    step();
    n_tests++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL eom_halt_valid: got %b want 0", bus.if_valid); end
    n_tests++; if (bus.imem_pc !== 32'h400) begin n_fail++; $display("FAIL eom_halt_pc: got %h want 00000400", bus.imem_pc); end
  endtask

  task automatic test_async_reset();
    bus.if_ready = 1'b0;
    do_redirect(32'h10);
    step();
    step();
    n_tests++; if (dut.r_count !== 2'd2) begin n_fail++; $display("FAIL ar_pre_count: got %0d want 2", dut.r_count); end
    #3;
    reset = 1'b0;
    #1;
    n_tests++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b want 0", bus.if_valid); end
    n_tests++; if (bus.imem_pc !== 32'h0) begin n_fail++; $display("FAIL ar_imem_pc: got %h want 00000000", bus.imem_pc); end
    n_tests++; if (bus.if_pc !== 32'h0 || bus.if_instr !== 32'h0) begin n_fail++; $display("FAIL ar_head: got pc %h instr %h want 0 0", bus.if_pc, bus.if_instr); end
    bus.if_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    step();
    n_tests++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0) begin n_fail++; $display("FAIL ar_restart0: got valid %b pc %h want 1 00000000", bus.if_valid, bus.if_pc); end
    n_tests++; if (bus.if_instr !== 32'hFFFF_0000) begin n_fail++; $display("FAIL ar_restart0_instr: got %h want ffff0000", bus.if_instr); end
    step();
    n_tests++; if (bus.if_pc !== 32'h4) begin n_fail++; $display("FAIL ar_restart1: got %h want 00000004", bus.if_pc); end
  endtask

  initial begin
    n_tests            = 0;
    n_fail             = 0;
    mem_zero           = 1'b1;
    bus.if_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_fault();
    test_end_of_memory();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit driving the byte-addressed, combinational-read instruction memory. It owns the fetch PC, presents it to the memory each cycle, and captures the returned 32-bit little-endian word into a small fetch queue. Instructions go to decode over a valid/ready handshake. Branch and jump redirects flush the queue, and misaligned or out-of-range PCs are reported as a fault instead of being fetched.

## Interface
- RESET_PC, 32'h0000_0000: fetch PC loaded on reset.
- MEM_SIZE_BYTES, 1024: instruction memory size in bytes. Must be a multiple of 4.
- QUEUE_DEPTH, 2: fetch queue entries. Must be ≥1.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_pc  out  32  byte address to the instruction memory; equals the fetch PC register.
- imem_instr  in  32  instruction word returned combinationally for imem_pc.
- redirect_valid  in  1  redirect request from execute.
- redirect_pc  in  32  redirect target byte address.
- if_valid  out  1  queue head is valid.
- if_ready  in  1  decode accepts the head this cycle.
- if_instr  out  32  head instruction.
- if_pc  out  32  head PC.
- if_fault  out  1  head is a fetch fault (misaligned or out-of-range PC).

## Operation
- States: FETCH and HALT.
  - FETCH issues fetches.
  - HALT issues none and waits for a redirect.
- Pop: if_valid && if_ready. The head is removed.
- Push condition, evaluated in FETCH with no redirect: count < QUEUE_DEPTH, or pop in the same cycle.
- Push behaviour:
  - Enqueue {imem_pc, imem_instr, fault=0}.
  - Fetch PC advances by 4.
- PC check, evaluated before the push:
  - Fault if fetch_pc[1:0] != 0, or fetch_pc > MEM_SIZE_BYTES-4 (unsigned 32-bit compare).
  - On a fault, enqueue {fetch_pc, 32'h0000_0013, fault=1} instead of the memory word.
  - The fault entry uses the same push condition as a normal entry.
  - State goes to HALT and the fetch PC holds.
- Redirect has the highest priority:
  - Queue is flushed: count=0, pointers reset.
  - fetch_pc <= redirect_pc and state <= FETCH.
  - Any same-cycle push or pop is discarded. The decode handshake of that cycle is void.
- Queue is a circular buffer.
  - Pointers wrap modulo QUEUE_DEPTH.
  - Count width is clog2(QUEUE_DEPTH+1).
  - Simultaneous push and pop leave count unchanged.
- PC arithmetic is 32-bit and wraps modulo 2^32. Wrap is unreachable without a fault first.
- Outputs if_instr, if_pc and if_fault come directly from the head entry registers. There is no combinational path from imem_instr to if_*.
- Reset values:
  - fetch_pc=RESET_PC, imem_pc=RESET_PC.
  - state=FETCH, count=0.
  - if_valid=0, if_instr=0, if_pc=0, if_fault=0.

## Timing
- First reset-release edge: first push (PC=RESET_PC). if_valid=1 after that edge.
- Steady state with if_ready held high: one instruction per cycle, no bubbles.
- Back-pressure:
  - With if_ready low, the queue fills to QUEUE_DEPTH and imem_pc holds.
  - When if_ready rises, the push resumes in the same cycle as the pop.
- Redirect in cycle N:
  - Cycle N+1: if_valid=0 and imem_pc=redirect_pc.
  - Cycle N+2: target instruction is valid at if_*.
  - Redirect-to-valid penalty is 2 cycles.
- Fault:
  - The fault entry appears one cycle after its push, like any entry.
  - No further pushes occur until a redirect.
  - if_valid drops once the fault entry is popped.
- Reset asserted mid-operation clears all state immediately (asynchronous), regardless of queue contents or a pending redirect.

## Test plan
- Reset release, memory holding 0x00000013 everywhere, if_ready=1:
  - if_pc sequence is 0, 4, 8, …
  - if_valid is continuous from the first edge.
  - if_fault=0 throughout.
- Back-pressure: if_ready=0 for 5 cycles, then 1.
  - count saturates at 2 and imem_pc holds at 8.
  - After if_ready rises, PCs 0, 4, 8, 12 are delivered in order, none lost or duplicated.
- Redirect to 0x40 while the queue is full and if_ready=1 in the same cycle:
  - Queue is flushed and the popped head is not counted.
  - Next cycle: imem_pc=0x40, if_valid=0.
  - Following cycle: if_pc=0x40.
- Redirect to 0x42:
  - One entry appears with if_fault=1, if_pc=0x42, if_instr=0x00000013.
  - State is HALT, imem_pc stays 0x42 and no further if_valid after the pop.
  - A later redirect to 0x0 resumes fetching.
- Sequential fetch reaching 0x3FC (MEM_SIZE_BYTES=1024):
  - 0x3FC is delivered normally.
  - Then 0x400 is delivered with if_fault=1 and the unit halts.
- Reset asserted asynchronously mid-cycle with 2 queued entries:
  - Immediately: if_valid=0, imem_pc=RESET_PC.
  - Normal fetch restarts after release.
